dbus_arbiter: RTL and testbench
===============================

Name: dbus_arbiter

Overview:
- Shares the single data-bus port among N_REQ requesters: the data-side MMU page-table walker, the instruction-side MMU walker and the core's load/store unit.
- Grants one requester at a time using round-robin priority.
- Latches the granted request and holds it on the downstream bus until the transaction completes (data_ok).
- Steers the response back to the owner only.

Parameters:
- N_REQ, 3, number of upstream requesters; index 0 = DMMU walker, 1 = IMMU walker, 2 = LSU.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- ureq  in  dbus_req_t[N_REQ]  upstream requests (valid, addr[63:0], size, strobe[7:0], data[63:0]).
- uresp  out  dbus_resp_t[N_REQ]  upstream responses (addr_ok, data_ok, data[63:0]).
- dreq  out  dbus_req_t  downstream request to the memory/cache.
- dresp  in  dbus_resp_t  downstream response.
- busy  out  1  high while a transaction is owned.
- owner  out  $clog2(N_REQ)  index of the current owner; holds the last owner when idle.

Behaviour:
- Reset (synchronous, active-high) clears every output and register:
  - state=IDLE, rr_ptr=0.
  - Latched request = 0, so dreq = all zero (valid=0).
  - busy=0, owner=0, every uresp = 0.
- Reset asserted mid-transaction abandons the transaction immediately. Any later downstream data_ok is ignored, because the arbiter is in IDLE.
- State machine, three states: IDLE, GRANT, WAIT.
  - IDLE, some ureq[i].valid=1 at a posedge:
    - Choose the first valid index scanning rr_ptr, rr_ptr+1, … modulo N_REQ.
    - Latch that whole request; owner <= i; busy <= 1; go to GRANT.
  - IDLE, no valid request: stay in IDLE.
  - GRANT: dreq = latched request with valid=1. Go to WAIT next cycle, unconditionally.
  - WAIT:
    - dreq keeps driving the latched request with valid=1.
    - When dresp.data_ok=1: clear the latched valid, busy <= 0, rr_ptr <= (owner+1) mod N_REQ, go to IDLE.
  - GRANT and WAIT share the completion rule. If dresp.data_ok=1 while in GRANT, complete exactly as in WAIT and go straight to IDLE.
- Response steering (combinational):
  - uresp[owner] = dresp while state is GRANT or WAIT.
  - Every other uresp[j] = 0, and all uresp = 0 in IDLE.
  - data_ok reaches the owner in the same cycle it arrives from downstream.
- Latency:
  - Upstream valid sampled at edge E (arbiter in IDLE) → dreq.valid=1 from E to the next edge.
  - Completion: data_ok in cycle M → arbiter IDLE from edge M+1. The earliest next grant is latched at edge M+2, because IDLE samples requests for one cycle.
  - Minimum gap of one idle cycle between back-to-back transactions.
- Requester obligations:
  - Hold valid and stable until data_ok.
  - Drop valid by the first edge after seeing data_ok.
  - The arbiter ignores upstream changes after latching, so the downstream request never glitches.
- A non-owner's valid is ignored, and it receives no addr_ok or data_ok, until that requester is granted.
- Simultaneous requests from all requesters: served in round-robin order starting at rr_ptr. No requester waits more than N_REQ-1 transactions.
- Owner drops valid before data_ok (protocol violation): the transaction still runs to data_ok, and the response is still steered to that index.
- Width rules:
  - rr_ptr and owner are $clog2(N_REQ) bits.
  - Wrap-around: the increment from N_REQ-1 returns to 0 (no power-of-two assumption).

Test Plan:
1. Reset, then hold all valid=0 for 10 cycles → dreq.valid=0, busy=0, owner=0, all uresp=0 throughout.
2. Only req0 valid, addr=0x8000_1008, size=MSIZE8; dresp.data_ok=1 with data=0x2000_0401 three cycles after dreq.valid rises:
   - dreq.addr=0x8000_1008.
   - uresp[0].data_ok=1 with data=0x2000_0401 in the same cycle; uresp[1] and uresp[2] stay 0.
   - busy falls at the next edge.
3. All three requesters valid from reset release, each transaction completing after 2 cycles:
   - Grant order is 0,1,2, then 0 again if req0 re-asserts.
   - Exactly one idle cycle between grants.
4. rr_ptr=2 (after serving req1), then req0 and req2 raise valid together → req2 granted first, then req0; rr_ptr wraps to 0 after req2.
5. During WAIT with owner=1, req1 changes addr and drops valid → dreq still shows the original addr with valid=1 until data_ok; uresp[1].data_ok=1 is still delivered.
6. Reset asserted in WAIT, then a stray dresp.data_ok=1 the next cycle:
   - State IDLE after reset; dreq.valid=0; all uresp=0.
   - rr_ptr=0; the next grant goes to the lowest valid index.

Source files
------------

// File: rtl/dbus_arbiter.sv
// Round-robin arbiter sharing one data-bus port among N_REQ requesters.
// The granted request is latched and held downstream until data_ok; responses go to the owner only.

package dbus_pkg;

  typedef enum logic [2:0] {
    MSIZE1,
    MSIZE2,
    MSIZE4,
    MSIZE8
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

endpackage

module dbus_arbiter
  import dbus_pkg::*;
#(
  parameter  int unsigned N_REQ = 3,
  localparam int unsigned IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  dbus_req_t     ureq  [N_REQ],
  output dbus_resp_t    uresp [N_REQ],
  output dbus_req_t     dreq,
  input  dbus_resp_t    dresp,
  output logic          busy,
  output logic [IW-1:0] owner
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    WAIT
  } state_t;

  state_t        state;
  logic [IW-1:0] rr_ptr;
  dbus_req_t     req_q;

  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic [IW:0]   scan_sum;
  logic [IW-1:0] scan_idx;
  logic [IW-1:0] owner_next;

  // Scan rr_ptr, rr_ptr+1, ... with an explicit wrap so N_REQ need not be a power of two.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_sum   = '0;
    scan_idx   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      scan_sum = {1'b0, rr_ptr} + (IW + 1)'(k);
      if (scan_sum >= (IW + 1)'(N_REQ)) begin
        scan_sum = scan_sum - (IW + 1)'(N_REQ);
      end
      scan_idx = scan_sum[IW-1:0];
      if (!pick_found && ureq[scan_idx].valid) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    owner_next = owner + IW'(1);
    if (owner == IW'(N_REQ - 1)) begin
      owner_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      rr_ptr <= '0;
      req_q  <= '0;
      busy   <= 1'b0;
      owner  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            req_q <= ureq[pick_idx];
            owner <= pick_idx;
            busy  <= 1'b1;
            state <= GRANT;
          end
        end
        GRANT, WAIT: begin
          if (dresp.data_ok) begin
            req_q.valid <= 1'b0;
            busy        <= 1'b0;
            rr_ptr      <= owner_next;
            state       <= IDLE;
          end else begin
            state <= WAIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dreq = req_q;

  always_comb begin
    for (int unsigned j = 0; j < N_REQ; j++) begin
      uresp[j] = '0;
      if (state != IDLE && owner == IW'(j)) begin
        uresp[j] = dresp;
      end
    end
  end

  a_busy_state : assert property (@(posedge clk) disable iff (reset) busy == (state != IDLE));
  a_valid_busy : assert property (@(posedge clk) disable iff (reset) dreq.valid == busy);

endmodule

// File: tb/tb_dbus_arbiter.sv
// Bench for dbus_arbiter: a transaction-level model checked every cycle plus directed literal checks.

module tb_dbus_arbiter;
  import dbus_pkg::*;

  localparam int N = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  dbus_req_t  ureq  [N];
  dbus_resp_t uresp [N];
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  logic       busy;
  logic [1:0] owner;

  dbus_arbiter #(.N_REQ(N)) dut (
    .clk   (clk),
    .reset (reset),
    .ureq  (ureq),
    .uresp (uresp),
    .dreq  (dreq),
    .dresp (dresp),
    .busy  (busy),
    .owner (owner)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int grant_log[$];
  int grant_cyc[$];

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Model: -1 when idle, otherwise the index currently owning the bus.
  int        m_cur = -1;
  int        m_rr = 0;
  int        m_owner = 0;
  dbus_req_t m_lat = '0;
  bit        started = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_cur = -1;
      m_rr = 0;
      m_owner = 0;
      m_lat = '0;
      started = 1'b1;
    end else if (m_cur < 0) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_rr + k) % N;
        if (m_cur < 0 && ureq[i].valid) begin
          m_lat = ureq[i];
          m_cur = i;
          m_owner = i;
        end
      end
    end else if (dresp.data_ok) begin
      m_lat.valid = 1'b0;
      m_rr = (m_cur + 1) % N;
      m_cur = -1;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("dreq", 256'(dreq), 256'(m_lat));
      chk("busy", 256'(busy), 256'(m_cur >= 0));
      chk("owner", 256'(owner), 256'(m_owner));
      for (int j = 0; j < N; j++) begin
        chk($sformatf("uresp%0d", j), 256'(uresp[j]), (m_cur == j) ? 256'(dresp) : 256'(0));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) ureq[i] = '0;
    dresp = '0;
  endtask

  task automatic set_req(input int i, input logic [63:0] a);
    ureq[i] = '0;
    ureq[i].valid = 1'b1;
    ureq[i].addr = a;
    ureq[i].size = MSIZE8;
    ureq[i].strobe = 8'hff;
    ureq[i].data = ~a;
  endtask

  task automatic wait_grant();
    int n;
    n = 0;
    while (!busy && n < 20) begin
      tick();
      n++;
    end
    chk("grant_wait", 256'(busy), 256'(1));
  endtask

  // lat = number of cycles dreq.valid is high, data_ok in the last of them.
  task automatic serve(input int lat, input bit drop);
    int o;
    wait_grant();
    if (!busy) return;
    o = int'(owner);
    grant_log.push_back(o);
    grant_cyc.push_back(cyc);
    repeat (lat - 1) tick();
    dresp.addr_ok = 1'b1;
    dresp.data_ok = 1'b1;
    dresp.data = 64'hC0DE_0000_0000_0000 | 64'(o);
    tick();
    dresp = '0;
    if (drop) ureq[o].valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp3[4];
    int exp4[2];
    logic [63:0] a5;
    exp3 = '{0, 1, 2, 0};
    exp4 = '{2, 0};
    a5 = 64'h0000_0000_4000_0100;

    clear_all();
    reset = 1'b1;
    tick();
    tick();
    chk("rst_dreq", 256'(dreq), 256'(0));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_owner", 256'(owner), 256'(0));
    for (int j = 0; j < N; j++) chk("rst_uresp", 256'(uresp[j]), 256'(0));
    reset = 1'b0;

    // 1: idle bus
    repeat (10) begin
      tick();
      chk("t1_valid", 256'(dreq.valid), 256'(0));
      chk("t1_busy", 256'(busy), 256'(0));
    end

    // 2: single requester, data_ok three cycles after dreq.valid rises
    set_req(0, 64'h8000_1008);
    tick();
    chk("t2_valid", 256'(dreq.valid), 256'(1));
    chk("t2_addr", 256'(dreq.addr), 256'(64'h8000_1008));
    chk("t2_size", 256'(dreq.size), 256'(MSIZE8));
    repeat (3) tick();
    dresp.data_ok = 1'b1;
    dresp.data = 64'h2000_0401;
    #1;
    chk("t2_dok0", 256'(uresp[0].data_ok), 256'(1));
    chk("t2_data0", 256'(uresp[0].data), 256'(64'h2000_0401));
    chk("t2_u1", 256'(uresp[1]), 256'(0));
    chk("t2_u2", 256'(uresp[2]), 256'(0));
    tick();
    chk("t2_busy_fall", 256'(busy), 256'(0));
    ureq[0].valid = 1'b0;
    dresp = '0;
    tick();

    // 3: all requesters from reset release
    reset = 1'b1;
    set_req(0, 64'h100);
    set_req(1, 64'h200);
    set_req(2, 64'h300);
    tick();
    reset = 1'b0;
    grant_log.delete();
    grant_cyc.delete();
    serve(2, 1);
    serve(2, 1);
    set_req(0, 64'h108);
    serve(2, 1);
    serve(2, 1);
    chk("t3_count", 256'(grant_log.size()), 256'(4));
    for (int k = 0; k < 4; k++) begin
      if (k < grant_log.size()) chk($sformatf("t3_order%0d", k), 256'(grant_log[k]), 256'(exp3[k]));
      if (k > 0 && k < grant_cyc.size())
        chk($sformatf("t3_gap%0d", k), 256'(grant_cyc[k] - grant_cyc[k-1]), 256'(3));
    end

    // 4: rr_ptr=2 after req1, then req0 and req2 together
    set_req(1, 64'h400);
    serve(2, 1);
    set_req(0, 64'h500);
    set_req(2, 64'h600);
    grant_log.delete();
    serve(2, 1);
    serve(2, 1);
    chk("t4_count", 256'(grant_log.size()), 256'(2));
    for (int k = 0; k < 2; k++)
      if (k < grant_log.size()) chk($sformatf("t4_order%0d", k), 256'(grant_log[k]), 256'(exp4[k]));

    // 5: owner changes addr and drops valid mid-transaction
    set_req(1, a5);
    wait_grant();
    chk("t5_owner", 256'(owner), 256'(1));
    tick();
    ureq[1].addr = 64'hDEAD_BEEF_0000_0000;
    ureq[1].valid = 1'b0;
    tick();
    tick();
    chk("t5_addr", 256'(dreq.addr), 256'(a5));
    chk("t5_valid", 256'(dreq.valid), 256'(1));
    dresp.data_ok = 1'b1;
    dresp.data = 64'h5555_AAAA;
    #1;
    chk("t5_dok1", 256'(uresp[1].data_ok), 256'(1));
    chk("t5_data1", 256'(uresp[1].data), 256'(64'h5555_AAAA));
    tick();
    dresp = '0;
    tick();

    // 6: reset in WAIT, stray data_ok afterwards
    set_req(2, 64'h700);
    wait_grant();
    chk("t6_owner2", 256'(owner), 256'(2));
    tick();
    reset = 1'b1;
    ureq[2] = '0;
    tick();
    reset = 1'b0;
    dresp.data_ok = 1'b1;
    dresp.data = 64'h0BAD;
    tick();
    chk("t6_busy", 256'(busy), 256'(0));
    chk("t6_valid", 256'(dreq.valid), 256'(0));
    for (int j = 0; j < N; j++) chk($sformatf("t6_uresp%0d", j), 256'(uresp[j]), 256'(0));
    dresp = '0;
    set_req(1, 64'h800);
    set_req(2, 64'h900);
    wait_grant();
    chk("t6_next_owner", 256'(owner), 256'(1));
    tick();
    dresp.data_ok = 1'b1;
    tick();
    clear_all();
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
